// File: rtl/elevator_car_ctrl.sv
// Single-car SCAN elevator controller: latches floor calls, steps one floor per travel period, dwells at stops.
// Optional ELEVATOR_ESTOP_EN adds an estop input that freezes the FSM and timers while requests keep latching.
package elevator_types_pkg;
  typedef logic [3:0] floor_t;
endpackage

module elevator_car_ctrl
  import elevator_types_pkg::*;
#(
  parameter int NUM_FLOORS    = 10,
  parameter int TRAVEL_CYCLES = 50_000_000,
  parameter int DOOR_CYCLES   = 100_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
`ifdef ELEVATOR_ESTOP_EN
  input  logic                  estop,
`endif
  input  logic [NUM_FLOORS-1:0] req_i,
  output floor_t                current_floor,
  output logic                  door_open,
  output logic                  moving_up,
  output logic                  moving_down,
  output logic [NUM_FLOORS-1:0] pending_o
);

  localparam int TMAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int TW   = (TMAX < 2) ? 1 : $clog2(TMAX);
  localparam logic [TW-1:0] TR_LD = TW'(TRAVEL_CYCLES - 1);
  localparam logic [TW-1:0] DR_LD = TW'(DOOR_CYCLES - 1);
  localparam floor_t        TOP   = floor_t'(NUM_FLOORS - 1);

  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOORS_OPEN} state_t;

  state_t                  r_state, w_nstate;
  floor_t                  r_floor, w_nfloor, w_nf_up, w_nf_dn;
  logic [TW-1:0]           r_timer, w_ntimer;
  logic                    r_dir_up, w_ndir_up;
  logic [NUM_FLOORS-1:0]   r_pend, w_clr;
  logic                    r_door, r_up, r_dn;
  logic                    w_frz, w_above, w_below;

`ifdef ELEVATOR_ESTOP_EN
  assign w_frz = estop;
`else
  assign w_frz = 1'b0;
`endif

  function automatic logic any_above(input logic [NUM_FLOORS-1:0] p, input floor_t f);
    any_above = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++)
      if (i > int'(f)) any_above = any_above | p[i];
  endfunction

  function automatic logic any_below(input logic [NUM_FLOORS-1:0] p, input floor_t f);
    any_below = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++)
      if (i < int'(f)) any_below = any_below | p[i];
  endfunction

  always_comb begin
    w_nstate  = r_state;
    w_nfloor  = r_floor;
    w_ntimer  = r_timer;
    w_ndir_up = r_dir_up;
    w_clr     = '0;
    w_nf_up   = (r_floor == TOP) ? r_floor : r_floor + floor_t'(1);
    w_nf_dn   = (r_floor == '0) ? r_floor : r_floor - floor_t'(1);
    w_above   = any_above(r_pend, r_floor);
    w_below   = any_below(r_pend, r_floor);
    case (r_state)
      IDLE: begin
        if (r_pend[r_floor]) begin
          w_nstate        = DOORS_OPEN;
          w_clr[r_floor]  = 1'b1;
          w_ntimer        = DR_LD;
        end else if (w_above && (r_dir_up || !w_below)) begin
          w_nstate  = MOVE_UP;
          w_ntimer  = TR_LD;
          w_ndir_up = 1'b1;
        end else if (w_below) begin
          w_nstate  = MOVE_DOWN;
          w_ntimer  = TR_LD;
          w_ndir_up = 1'b0;
        end
      end
      MOVE_UP: begin
        if (r_timer != '0) w_ntimer = r_timer - TW'(1);
        else begin
          w_nfloor = w_nf_up;
          if (r_pend[w_nf_up]) begin
            w_nstate       = DOORS_OPEN;
            w_clr[w_nf_up] = 1'b1;
            w_ntimer       = DR_LD;
          end else if (any_above(r_pend, w_nf_up)) w_ntimer = TR_LD;
          else w_nstate = IDLE;
        end
      end
      MOVE_DOWN: begin
        if (r_timer != '0) w_ntimer = r_timer - TW'(1);
        else begin
          w_nfloor = w_nf_dn;
          if (r_pend[w_nf_dn]) begin
            w_nstate       = DOORS_OPEN;
            w_clr[w_nf_dn] = 1'b1;
            w_ntimer       = DR_LD;
          end else if (any_below(r_pend, w_nf_dn)) w_ntimer = TR_LD;
          else w_nstate = IDLE;
        end
      end
      DOORS_OPEN: begin
        // A call for the floor we're standing at just extends the dwell.
        w_clr[r_floor] = 1'b1;
        if (req_i[r_floor] || r_pend[r_floor]) w_ntimer = DR_LD;
        else if (r_timer != '0) w_ntimer = r_timer - TW'(1);
        else if ((r_dir_up && w_above) || (!w_below && w_above)) begin
          w_nstate  = MOVE_UP;
          w_ntimer  = TR_LD;
          w_ndir_up = 1'b1;
        end else if (w_below) begin
          w_nstate  = MOVE_DOWN;
          w_ntimer  = TR_LD;
          w_ndir_up = 1'b0;
        end else w_nstate = IDLE;
      end
      default: w_nstate = IDLE;
    endcase
    if (w_frz) begin
      w_nstate  = r_state;
      w_nfloor  = r_floor;
      w_ntimer  = r_timer;
      w_ndir_up = r_dir_up;
      w_clr     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_floor  <= '0;
      r_timer  <= '0;
      r_dir_up <= 1'b1;
      r_pend   <= '0;
      r_door   <= 1'b0;
      r_up     <= 1'b0;
      r_dn     <= 1'b0;
    end else begin
      r_state  <= w_nstate;
      r_floor  <= w_nfloor;
      r_timer  <= w_ntimer;
      r_dir_up <= w_ndir_up;
      r_pend   <= (r_pend | req_i) & ~w_clr;
      r_door   <= (w_nstate == DOORS_OPEN);
      r_up     <= (w_nstate == MOVE_UP) && !w_frz;
      r_dn     <= (w_nstate == MOVE_DOWN) && !w_frz;
    end
  end

  assign current_floor = r_floor;
  assign door_open     = r_door;
  assign moving_up     = r_up;
  assign moving_down   = r_dn;
  assign pending_o     = r_pend;

endmodule

// File: tb/tb_elevator_car_ctrl.sv
// Directed bench for elevator_car_ctrl with short travel/dwell times; estop checks build under ELEVATOR_ESTOP_EN.
module tb_elevator_car_ctrl;
  localparam int NF = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic [NF-1:0] req;
  logic [3:0]    floor;
  logic          door, up, dn;
  logic [NF-1:0] pend;
`ifdef ELEVATOR_ESTOP_EN
  logic          estop;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  elevator_car_ctrl #(.NUM_FLOORS(NF), .TRAVEL_CYCLES(4), .DOOR_CYCLES(3)) dut (
    .clk(clk), .reset(reset),
`ifdef ELEVATOR_ESTOP_EN
    .estop(estop),
`endif
    .req_i(req), .current_floor(floor), .door_open(door),
    .moving_up(up), .moving_down(dn), .pending_o(pend)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int extra, dcyc, mx;
    reset = 1'b1;
    req   = '0;
`ifdef ELEVATOR_ESTOP_EN
    estop = 1'b0;
`endif
    tick(3);
    reset = 1'b0;
    tick(10);
    chk("rst_floor", 32'(floor), 0);
    chk("rst_door", 32'(door), 0);
    chk("rst_up", 32'(up), 0);
    chk("rst_dn", 32'(dn), 0);
    chk("rst_pend", 32'(pend), 0);

    // single call to floor 2 from idle at floor 0
    req[2] = 1'b1; tick(1); req = '0;
    chk("f2_pend_e1", 32'(pend), 32'h004);
    chk("f2_up_e1", 32'(up), 0);
    tick(1); chk("f2_up_e2", 32'(up), 1);
    tick(3); chk("f2_floor_e5", 32'(floor), 0);
    tick(1); chk("f2_floor_e6", 32'(floor), 1);
    tick(4); chk("f2_floor_e10", 32'(floor), 2);
    chk("f2_door_e10", 32'(door), 1);
    chk("f2_pend_e10", 32'(pend), 0);
    tick(2); chk("f2_door_e12", 32'(door), 1);
    tick(1); chk("f2_door_e13", 32'(door), 0);
    chk("f2_up_e13", 32'(up), 0);

    // travel to 5, then calls at the current floor
    req[5] = 1'b1; tick(1); req = '0;
    tick(16);
    chk("f5_floor", 32'(floor), 5);
    chk("f5_idle", 32'({door, up, dn}), 0);
    req[5] = 1'b1; tick(1); req = '0;
    tick(1); chk("here_door_e2", 32'(door), 1);
    tick(2); chk("here_door_e4", 32'(door), 1);
    tick(1); chk("here_door_e5", 32'(door), 0);
    chk("here_floor", 32'(floor), 5);
    req[5] = 1'b1; tick(1); req = '0;
    tick(1); chk("rep_door_e2", 32'(door), 1);
    req[5] = 1'b1; tick(1); req = '0;
    chk("rep_pend_e3", 32'(pend), 0);
    tick(2); chk("rep_door_e5", 32'(door), 1);
    tick(1); chk("rep_door_e6", 32'(door), 0);

    // to floor 4, then 4->7 up with a call at 1 arriving en route
    req[4] = 1'b1; tick(1); req = '0;
    tick(8);
    chk("f4_floor", 32'(floor), 4);
    chk("f4_idle", 32'({door, up, dn}), 0);
    req[7] = 1'b1;
    extra = 0; dcyc = 0;
    for (int e = 1; e <= 44; e++) begin
      tick(1);
      if (door) begin
        dcyc++;
        if (floor != 4'd7 && floor != 4'd1) extra++;
      end
      if (e == 1) begin req = '0; chk("scan_pend_e1", 32'(pend), 32'h080); end
      if (e == 2) req[1] = 1'b1;
      if (e == 3) begin req = '0; chk("scan_pend_e3", 32'(pend), 32'h082); end
      if (e == 14) chk("scan_f7_door", 32'({floor, door}), 32'({4'd7, 1'b1}));
      if (e == 17) chk("scan_rev_dn", 32'({floor, dn}), 32'({4'd7, 1'b1}));
      if (e == 21) chk("scan_f6_e21", 32'(floor), 6);
      if (e == 41) chk("scan_f1_door", 32'({floor, door, 10'(pend)}), 32'({4'd1, 1'b1, 10'd0}));
      if (e == 44) chk("scan_idle", 32'({door, up, dn}), 0);
    end
    chk("scan_no_extra_stop", 32'(extra), 0);
    chk("scan_door_cycles", 32'(dcyc), 6);

    // held call at the top floor
    req[9] = 1'b1;
    mx = 0;
    for (int e = 1; e <= 63; e++) begin
      tick(1);
      if (int'(floor) > mx) mx = int'(floor);
      if (e == 34) chk("top_arrive", 32'({floor, door}), 32'({4'd9, 1'b1}));
      if (e == 60) begin
        chk("top_hold_door", 32'(door), 1);
        chk("top_hold_pend", 32'(pend), 0);
        req = '0;
      end
      if (e == 63) chk("top_release", 32'({floor, door}), 32'({4'd9, 1'b0}));
    end
    chk("top_max_floor", 32'(mx), 9);

    // reset while moving 3 -> 6
    req[3] = 1'b1; tick(1); req = '0;
    tick(28);
    chk("f3_floor", 32'({floor, door}), 32'({4'd3, 1'b0}));
    req[6] = 1'b1; tick(1); req = '0;
    tick(5); chk("mv36_e6", 32'({floor, up}), 32'({4'd4, 1'b1}));
    tick(1);
    reset = 1'b1; tick(1);
    chk("midrst_floor", 32'(floor), 0);
    chk("midrst_flags", 32'({door, up, dn}), 0);
    chk("midrst_pend", 32'(pend), 0);
    reset = 1'b0;
    tick(2); chk("midrst_stay", 32'({floor, door, up, dn}), 0);

`ifdef ELEVATOR_ESTOP_EN
    req[2] = 1'b1; tick(1); req = '0;
    tick(1); chk("es_up_e2", 32'(up), 1);
    tick(1);
    estop = 1'b1; tick(1);
    chk("es_up_frozen", 32'(up), 0);
    req[5] = 1'b1; tick(1); req = '0;
    chk("es_req_latch", 32'(pend), 32'h024);
    tick(3);
    chk("es_floor_e8", 32'({floor, up, dn}), 0);
    estop = 1'b0; tick(1);
    chk("es_resume_up", 32'({floor, up}), 32'({4'd0, 1'b1}));
    tick(1); chk("es_floor_e10", 32'(floor), 0);
    tick(1); chk("es_floor_e11", 32'(floor), 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
